lvds_serial_tx: RTL and testbench

Parallel-to-serial LVDS transmitter. It is the transmit end of the 8-bit serial link whose receiver deserializes MSB-first words on a free-running modulo-8 bit counter. The block accepts words over a valid/ready handshake and buffers one word ahead of the shifter. It drives one bit per `lvds_clk` cycle on fixed word boundaries, and inserts an idle word whenever no data is available, so the receiver's framing never slips.

---
 rtl/lvds_serial_tx.sv | 85 ++++++++
 tb/tb_lvds_serial_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_serial_tx.sv
// MSB-first 8-bit serializer with a one-word holding register.
// Word boundaries are fixed by a free-running bit counter; idle words fill any gap.
module lvds_serial_tx #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] IDLE_WORD = 8'hBC
) (
  input  logic              lvds_clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              lvds_d,
  output logic              lvds_frame,
  output logic [15:0]       tx_cnt
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] hold_data;
  logic              hold_full;

  logic load;
  logic accept;
  logic use_hold;
  logic send_data;

  assign load      = (bit_cnt == LAST_BIT);
  assign s_ready   = tx_en && (!hold_full || load);
  assign accept    = s_valid && s_ready;
  // A held word always goes ahead of a newly accepted one to preserve order.
  assign use_hold  = load && hold_full && tx_en;
  assign send_data = use_hold || (load && accept);

  assign lvds_d     = shift_reg[DATA_W-1];
  assign lvds_frame = (bit_cnt == '0);

  function automatic logic [DATA_W-1:0] next_word(
    input logic              from_hold,
    input logic              from_input,
    input logic [DATA_W-1:0] held,
    input logic [DATA_W-1:0] incoming
  );
    if (from_hold)
      return held;
    else if (from_input)
      return incoming;
    else
      return IDLE_WORD;
  endfunction

  always_ff @(posedge lvds_clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift_reg <= IDLE_WORD;
      tx_cnt    <= '0;
    end else begin
      bit_cnt <= bit_cnt + 1'b1;
      if (load) begin
        shift_reg <= next_word(use_hold, accept, hold_data, s_data);
        if (send_data)
          tx_cnt <= tx_cnt + 16'd1;
      end else begin
        shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
      end
    end
  end

  // A word accepted on a load edge into an empty hold bypasses straight to the shifter.
  always_ff @(posedge lvds_clk or posedge rst) begin
    if (rst) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (accept && !(load && !hold_full)) begin
      hold_data <= s_data;
      hold_full <= 1'b1;
    end else if (use_hold) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lvds_serial_tx.sv
// Directed bench for lvds_serial_tx: a queue-based link model checked every cycle,
// plus literal frame and counter expectations per scenario.
module tb_lvds_serial_tx;

  localparam logic [7:0] IDLE = 8'hBC;

  logic        lvds_clk = 1'b0;
  logic        rst;
  logic        tx_en;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        lvds_d;
  logic        lvds_frame;
  logic [15:0] tx_cnt;

  lvds_serial_tx #(.DATA_W(8), .IDLE_WORD(8'hBC)) dut (
    .lvds_clk  (lvds_clk),
    .rst       (rst),
    .tx_en     (tx_en),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .lvds_d    (lvds_d),
    .lvds_frame(lvds_frame),
    .tx_cnt    (tx_cnt)
  );

  always #5 lvds_clk = ~lvds_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Link model: words waiting to go out, the word on the line, position within it.
  logic [7:0]  m_q[$];
  logic [7:0]  m_word;
  int          m_phase;
  logic [15:0] m_cnt;
  bit          m_acc;

  // Received-frame log built from the DUT line.
  logic [7:0] frames_q[$];
  logic [7:0] acc_w;
  int         nbits;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_ready();
    return tx_en && (m_q.size() == 0 || m_phase == 7);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_word  = IDLE;
    m_phase = 0;
    m_cnt   = 16'd0;
    m_acc   = 1'b0;
  endtask

  task automatic model_step();
    m_acc = s_valid && m_ready();
    if (m_acc)
      m_q.push_back(s_data);
    if (m_phase == 7) begin
      if (tx_en && m_q.size() > 0) begin
        m_word = m_q.pop_front();
        m_cnt  = m_cnt + 16'd1;
      end else begin
        m_word = IDLE;
      end
      m_phase = 0;
    end else begin
      m_phase++;
    end
  endtask

  task automatic compare();
    chk("lvds_d", lvds_d, m_word[7 - m_phase]);
    chk("lvds_frame", lvds_frame, (m_phase == 0));
    chk("tx_cnt", tx_cnt, m_cnt);
    chk("s_ready", s_ready, m_ready());
  endtask

  task automatic tick();
    @(posedge lvds_clk);
    if (!rst)
      model_step();
    @(negedge lvds_clk);
    cyc++;
    compare();
    acc_w = {acc_w[6:0], lvds_d};
    if (lvds_frame)
      nbits = 1;
    else if (nbits > 0)
      nbits++;
    if (nbits == 8) begin
      frames_q.push_back(acc_w);
      nbits = 0;
    end
  endtask

  task automatic wait_phase(input int p);
    bit hit = 1'b0;
    for (int i = 0; i < 16 && !hit; i++) begin
      if (m_phase == p)
        hit = 1'b1;
      else
        tick();
    end
    if (!hit)
      chk("phase_timeout", m_phase, p);
  endtask

  task automatic chk_frame(input string name, input int i, input logic [7:0] exp);
    if (i < frames_q.size())
      chk(name, frames_q[i], exp);
    else
      chk({name, "_missing"}, frames_q.size(), i + 1);
  endtask

  task automatic send_one(input logic [7:0] w);
    s_valid = 1'b1;
    s_data  = w;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    #1;
    model_reset();
    repeat (2) tick();
    frames_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    int   idx;
    int   last_rdy;
    logic [7:0] b2b[4];

    rst     = 1'b1;
    tx_en   = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    acc_w   = 8'h00;
    nbits   = 0;
    model_reset();
    repeat (3) tick();

    // Reset state
    chk("rst_lvds_d", lvds_d, 1'b1);
    chk("rst_frame", lvds_frame, 1'b1);
    chk("rst_tx_cnt", tx_cnt, 16'd0);
    chk("rst_s_ready", s_ready, 1'b1);

    // Idle after reset release
    frames_q.delete();
    rst = 1'b0;
    repeat (32) tick();
    chk("idle_frames", frames_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk_frame("idle_word", i, IDLE);
    chk("idle_tx_cnt", tx_cnt, 16'd0);

    // Single word accepted mid-frame
    wait_phase(3);
    frames_q.delete();
    send_one(8'h5A);
    repeat (24) tick();
    chk_frame("single_pre", 0, IDLE);
    chk_frame("single_word", 1, 8'h5A);
    chk_frame("single_post", 2, IDLE);
    chk("single_tx_cnt", tx_cnt, 16'd1);

    // Bypass on a load edge
    wait_phase(7);
    frames_q.delete();
    send_one(8'hC3);
    chk("bypass_frame", lvds_frame, 1'b1);
    chk("bypass_msb", lvds_d, 1'b1);
    tick();
    chk("bypass_hold_empty", s_ready, 1'b1);
    repeat (10) tick();
    chk_frame("bypass_word", 0, 8'hC3);
    chk("bypass_tx_cnt", tx_cnt, 16'd2);

    // Back-to-back with s_valid held high
    reset_cycle();
    b2b = '{8'h01, 8'h02, 8'h03, 8'h04};
    idx = 0;
    last_rdy = -1;
    s_valid = 1'b1;
    s_data  = b2b[0];
    for (int i = 0; i < 80 && idx < 4; i++) begin
      tick();
      if (m_acc) begin
        idx++;
        if (idx < 4)
          s_data = b2b[idx];
        else
          s_valid = 1'b0;
      end
      if (idx >= 2 && s_valid && s_ready) begin
        if (last_rdy >= 0)
          chk("b2b_ready_gap", cyc - last_rdy, 8);
        last_rdy = cyc;
      end
    end
    chk("b2b_accepts", idx, 4);
    s_valid = 1'b0;
    repeat (24) tick();
    chk_frame("b2b_lead_idle", 0, IDLE);
    for (int i = 0; i < 4; i++)
      chk_frame("b2b_word", i + 1, b2b[i]);
    chk_frame("b2b_tail_idle", 5, IDLE);
    chk("b2b_tx_cnt", tx_cnt, 16'd4);

    // Enable gating with a held word
    wait_phase(2);
    send_one(8'hF0);
    wait_phase(5);
    tx_en = 1'b0;
    frames_q.delete();
    for (int i = 0; i < 64 && frames_q.size() < 4; i++) begin
      tick();
      chk("gate_s_ready", s_ready, 1'b0);
    end
    chk("gate_idle_frames", frames_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk_frame("gate_idle", i, IDLE);
    tx_en = 1'b1;
    repeat (8) tick();
    chk_frame("gate_word", 4, 8'hF0);
    chk("gate_tx_cnt", tx_cnt, 16'd5);

    // Mid-word reset with a word shifting and another held
    wait_phase(7);
    send_one(8'hAA);
    send_one(8'h55);
    wait_phase(4);
    rst = 1'b1;
    #1;
    chk("midrst_lvds_d", lvds_d, 1'b1);
    chk("midrst_frame", lvds_frame, 1'b1);
    chk("midrst_tx_cnt", tx_cnt, 16'd0);
    chk("midrst_s_ready", s_ready, 1'b1);
    model_reset();
    repeat (2) tick();
    frames_q.delete();
    rst = 1'b0;
    repeat (32) tick();
    chk("midrst_frames", frames_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk_frame("midrst_idle", i, IDLE);
    chk("midrst_tx_cnt_after", tx_cnt, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
